id_ex_pipe_stage: RTL

- Parametrised ID/EX pipeline stage.
- Replaces the bare always-latching ID->EX register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and bubble masking of side-effecting control bits.
- Sits between decode/register-read and the execute stage.
- Lets the hazard unit stall EX without a combinational ready path back into ID, and lets branch resolution kill the in-flight instruction.

---
 rtl/id_ex_pipe_stage.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline stage: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush and bubble masking of side-effecting control bits.
// Optional stall-cycle counter enabled by defining PIPE_PERF_CNT_EN.
module id_ex_pipe_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALU_OP_W   = 3
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W      = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       srcA_D,
  input  logic [XLEN-1:0]       register_file_srcB_D,
  input  logic [REG_ADDR_W-1:0] rs2_D,
  input  logic [REG_ADDR_W-1:0] rd_D,
  input  logic [XLEN-1:0]       sign_imm_D,
  input  logic [XLEN-1:0]       PC_plus4_D,
  input  logic                  ctrl_register_file_WE_D,
  input  logic                  ctrl_srcB_D,
  input  logic                  ctrl_register_file_WA_D,
  input  logic                  ctrl_data_memory_WE_D,
  input  logic                  ctrl_result_D,
  input  logic                  ctrl_branch_D,
  input  logic [ALU_OP_W-1:0]   ctrl_ALU_op_D,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       srcA_E,
  output logic [XLEN-1:0]       register_file_srcB_E,
  output logic [REG_ADDR_W-1:0] rs2_E,
  output logic [REG_ADDR_W-1:0] rd_E,
  output logic [XLEN-1:0]       sign_imm_E,
  output logic [XLEN-1:0]       PC_plus4_E,
  output logic                  ctrl_register_file_WE_E,
  output logic                  ctrl_srcB_E,
  output logic                  ctrl_register_file_WA_E,
  output logic                  ctrl_data_memory_WE_E,
  output logic                  ctrl_result_E,
  output logic                  ctrl_branch_E,
  output logic [ALU_OP_W-1:0]   ctrl_ALU_op_E
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]       src_a;
    logic [XLEN-1:0]       src_b;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       sign_imm;
    logic [XLEN-1:0]       pc_plus4;
    logic                  rf_we;
    logic                  src_b_sel;
    logic                  rf_wa;
    logic                  dm_we;
    logic                  result;
    logic                  branch;
    logic [ALU_OP_W-1:0]   alu_op;
  } entry_t;

  // Bit 0 is the main-entry valid, bit 1 the skid-entry valid.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b11
  } state_e;

  state_e state_q;
  entry_t main_q;
  entry_t skid_q;
  entry_t in_entry;
  logic   in_ready_q;
  logic   main_valid;
  logic   accept;
  logic   retire;

  assign main_valid = state_q[0];
  assign accept     = in_valid && in_ready_q;
  assign retire     = main_valid && out_ready;

  // Gather the decode-side fields into one entry.
  always_comb begin
    in_entry           = '0;
    in_entry.src_a     = srcA_D;
    in_entry.src_b     = register_file_srcB_D;
    in_entry.rs2       = rs2_D;
    in_entry.rd        = rd_D;
    in_entry.sign_imm  = sign_imm_D;
    in_entry.pc_plus4  = PC_plus4_D;
    in_entry.rf_we     = ctrl_register_file_WE_D;
    in_entry.src_b_sel = ctrl_srcB_D;
    in_entry.rf_wa     = ctrl_register_file_WA_D;
    in_entry.dm_we     = ctrl_data_memory_WE_D;
    in_entry.result    = ctrl_result_D;
    in_entry.branch    = ctrl_branch_D;
    in_entry.alu_op    = ctrl_ALU_op_D;
  end

  // Occupancy FSM with main/skid storage; in_ready is registered so that an EX
  // stall never reaches ID combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      // Data fields are left stale; only the valids matter.
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            main_q  <= in_entry;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (retire && accept) begin
            main_q <= in_entry;
          end else if (retire) begin
            state_q <= StEmpty;
          end else if (accept) begin
            skid_q     <= in_entry;
            state_q    <= StFull;
            in_ready_q <= 1'b0;
          end
        end
        StFull: begin
          if (retire) begin
            main_q     <= skid_q;
            state_q    <= StOne;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= StEmpty;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;

  // Head entry to EX; side-effecting controls are forced low on bubbles.
  always_comb begin
    srcA_E                  = main_q.src_a;
    register_file_srcB_E    = main_q.src_b;
    rs2_E                   = main_q.rs2;
    rd_E                    = main_q.rd;
    sign_imm_E              = main_q.sign_imm;
    PC_plus4_E              = main_q.pc_plus4;
    ctrl_register_file_WE_E = main_q.rf_we && main_valid;
    ctrl_srcB_E             = main_q.src_b_sel;
    ctrl_register_file_WA_E = main_q.rf_wa;
    ctrl_data_memory_WE_E   = main_q.dm_we && main_valid;
    ctrl_result_E           = main_q.result;
    ctrl_branch_E           = main_q.branch && main_valid;
    ctrl_ALU_op_E           = main_q.alu_op;
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;

  // Saturating count of cycles EX held a valid entry; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (main_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule
